// File: rtl/gate_sweep_n.sv
// gate_sweep_n
//   N-input reduction gate with a sequential truth-table sweeper. A start
//   request latches the gate mode and steps vec through every input
//   combination, one per clock. Each result is written into table_out at
//   its combination index, and ones counts the results that are 1.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      sweep request, honoured only in IDLE
//   mode       in   3      gate select, latched on accepted start
//                          (0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 force 0)
//   vec        out  N      input combination currently applied to the gate
//   s          out  1      combinational gate output for vec under latched mode
//   table_out  out  2**N   truth table, bit k = result for combination k
//   ones       out  N+1    count of 1 results recorded so far
//   busy       out  1      high while sweeping
//   done       out  1      one-cycle pulse at sweep completion
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; table_out/ones hold the last result
// SWEEP | one combination evaluated and recorded per clock
// DONE  | done pulse for one cycle, start ignored, back to IDLE
module gate_sweep_n #(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        mode,
  output logic [N-1:0]      vec,
  output logic              s,
  output logic [2**N-1:0]   table_out,
  output logic [N:0]        ones,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] VEC_LAST = '1;

  state_t      state;
  logic [2:0]  mode_q;

  // OR is built in De Morgan form; the inverted gates complement their base.
  always_comb begin
    s = 1'b0;
    case (mode_q)
      3'd0:    s = &vec;
      3'd1:    s = ~&(~vec);
      3'd2:    s = ~(&vec);
      3'd3:    s = ~(~&(~vec));
      3'd4:    s = ^vec;
      3'd5:    s = ~(^vec);
      default: s = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 3'd0;
      vec       <= '0;
      table_out <= '0;
      ones      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q    <= mode;
            vec       <= '0;
            table_out <= '0;
            ones      <= '0;
            busy      <= 1'b1;
            state     <= SWEEP;
          end
        end
        SWEEP: begin
          table_out[vec] <= s;
          ones           <= ones + {{N{1'b0}}, s};
          if (vec == VEC_LAST) begin
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            vec <= vec + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
